// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and pixel packing for the OV7670 capture path
//
// Purpose: FSM state encoding and the RGB565 -> RGB444 packing function used
// by ov7670_capture_ctrl.
// Contents:
//   cam_state_t     IDLE / SYNC / CAPTURE
//   rgb565_to_444   keeps the top 4 bits of each colour channel
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_t;

  // R[15:12], G[10:7], B[4:1]: top four bits of each 565 channel.
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/cam_byte_pairer.sv
// rtl/cam_byte_pairer.sv - pairs camera bytes into 16-bit pixels
//
// Purpose: tracks byte phase inside a line, assembles {first, second} byte
// pixels and detects the falling edge of href.
// Ports:
//   pclk, reset    clock, synchronous active-high reset
//   i_en           pairing enabled (capture in progress)
//   i_href         line valid from camera
//   i_data[7:0]    camera byte
//   o_pix_valid    second byte of a pixel is on i_data this cycle
//   o_pix[15:0]    assembled pixel, valid with o_pix_valid
//   o_href_fall    href was high last cycle and is low now
module cam_byte_pairer (
  input  logic        pclk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_pix_valid,
  output logic [15:0] o_pix,
  output logic        o_href_fall
);

  logic       r_phase;
  logic [7:0] r_hi;
  logic       r_href_d;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_phase  <= 1'b0;
      r_hi     <= 8'd0;
      r_href_d <= 1'b0;
    end else begin
      r_href_d <= i_href;
      // Phase returns to "first byte" whenever href is low, so every new
      // line starts aligned even after an odd-length line.
      if (i_en && i_href) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= i_data;
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

  // Pixel is presented combinationally on the cycle its second byte arrives
  // so the top can register the write one pclk later.
  assign o_pix_valid = i_en & i_href & r_phase;
  assign o_pix       = {r_hi, i_data};
  assign o_href_fall = r_href_d & ~i_href;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// rtl/ov7670_capture_ctrl.sv - OV7670 frame capture into a decimated frame buffer
//
// Purpose: waits for a clean vsync pulse, captures one frame at a time, keeps
// every DECIM-th pixel in x and y and writes it to a linear frame buffer.
// Ports:
//   pclk, reset            camera clock, synchronous active-high reset
//   i_capture_en           request continuous capture
//   i_vsync                high = vertical blanking
//   i_href                 high = byte on i_data valid
//   i_data[7:0]            camera bytes, two per pixel
//   o_we                   one-pclk frame-buffer write strobe
//   o_waddr[ADDR_W-1:0]    write address
//   o_wdata[PIX_W-1:0]     write pixel (RGB565 or RGB444)
//   o_busy                 in SYNC or CAPTURE
//   o_frame_done           one-pclk pulse at end of captured frame
//   o_frame_cnt[7:0]       completed frames, wrapping
//   o_line_err             sticky malformed-line flag for the current/last frame
module ov7670_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2,
  parameter int PIX_W    = 16,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              i_capture_en,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [PIX_W-1:0]  o_wdata,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_line_err
);

  localparam int H_OUT  = H_ACTIVE / DECIM;
  localparam int X_W    = $clog2(H_ACTIVE + 1);
  localparam int Y_W    = $clog2(V_ACTIVE + 1);
  localparam int BCNT_W = $clog2(2 * H_ACTIVE + 2);

  cam_state_t r_state;
  cam_state_t w_next;

  logic r_vsync_d;
  logic r_vs_seen;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_capturing;
  logic w_cap_entry;
  logic w_frame_end;

  logic              w_pix_valid;
  logic [15:0]       w_pix;
  logic              w_href_fall;
  logic [PIX_W-1:0]  w_pix_fmt;
  logic              w_keep;

  logic [X_W-1:0]    r_x;
  logic [1:0]        r_xsub;
  logic [ADDR_W-1:0] r_xcol;
  logic [Y_W-1:0]    r_y;
  logic [1:0]        r_ysub;
  logic [ADDR_W-1:0] r_line_base;
  logic [BCNT_W-1:0] r_bcnt;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [PIX_W-1:0]  r_wdata;
  logic              r_frame_done;
  logic [7:0]        r_frame_cnt;
  logic              r_line_err;

  assign w_vs_rise = i_vsync & ~r_vsync_d;
  assign w_vs_fall = r_vsync_d & ~i_vsync;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_vsync_d <= 1'b0;
      r_vs_seen <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vsync_d <= i_vsync;
      // Only a vsync high observed while already in SYNC arms the start, so
      // a frame entered mid-way (e.g. after reset) is never captured.
      if (r_state != ST_SYNC) r_vs_seen <= 1'b0;
      else if (i_vsync)       r_vs_seen <= 1'b1;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_capture_en) w_next = ST_SYNC;
      ST_SYNC:    if (r_vs_seen && w_vs_fall) w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_vs_rise) w_next = i_capture_en ? ST_SYNC : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_capturing = (r_state == ST_CAPTURE);
    o_busy      = (r_state == ST_SYNC) || (r_state == ST_CAPTURE);
    w_cap_entry = (r_state == ST_SYNC) && (w_next == ST_CAPTURE);
    w_frame_end = w_capturing && w_vs_rise;
  end

  cam_byte_pairer u_pairer (
    .pclk        (pclk),
    .reset       (reset),
    .i_en        (w_capturing),
    .i_href      (i_href),
    .i_data      (i_data),
    .o_pix_valid (w_pix_valid),
    .o_pix       (w_pix),
    .o_href_fall (w_href_fall)
  );

  if (PIX_W == 12) begin : g_rgb444
    assign w_pix_fmt = rgb565_to_444(w_pix);
  end else begin : g_rgb565
    assign w_pix_fmt = w_pix;
  end

  // x and y saturate at the active size, so overlong lines/frames stop
  // producing writes instead of wrapping back into the buffer.
  assign w_keep = w_pix_valid &&
                  (r_x != X_W'(H_ACTIVE)) && (r_y != Y_W'(V_ACTIVE)) &&
                  (r_xsub == 2'd0) && (r_ysub == 2'd0);

  // ---------------- position and address counters ----------------
  always_ff @(posedge pclk) begin
    if (reset || !w_capturing) begin
      r_x         <= '0;
      r_xsub      <= 2'd0;
      r_xcol      <= '0;
      r_y         <= '0;
      r_ysub      <= 2'd0;
      r_line_base <= '0;
      r_bcnt      <= '0;
    end else if (w_href_fall) begin
      r_x    <= '0;
      r_xsub <= 2'd0;
      r_xcol <= '0;
      r_bcnt <= '0;
      if (r_y != Y_W'(V_ACTIVE)) r_y <= r_y + 1'b1;
      r_ysub <= (r_ysub == 2'(DECIM - 1)) ? 2'd0 : r_ysub + 2'd1;
      // Line base only moves past kept lines: base = (y/DECIM)*H_OUT.
      if (r_ysub == 2'd0) r_line_base <= r_line_base + ADDR_W'(H_OUT);
    end else begin
      if (i_href && (r_bcnt != {BCNT_W{1'b1}})) r_bcnt <= r_bcnt + 1'b1;
      if (w_pix_valid && (r_x != X_W'(H_ACTIVE))) begin
        r_x    <= r_x + 1'b1;
        r_xsub <= (r_xsub == 2'(DECIM - 1)) ? 2'd0 : r_xsub + 2'd1;
        if (r_xsub == 2'(DECIM - 1)) r_xcol <= r_xcol + 1'b1;
      end
    end
  end

  // ---------------- write port and status ----------------
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_line_err   <= 1'b0;
    end else begin
      r_we         <= w_keep;
      r_frame_done <= w_frame_end;
      if (w_keep) begin
        r_waddr <= r_line_base + r_xcol;
        r_wdata <= w_pix_fmt;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_cap_entry) begin
        r_line_err <= 1'b0;
      end else if (w_capturing &&
                   ((w_href_fall && (r_bcnt != BCNT_W'(2 * H_ACTIVE))) ||
                    (w_vs_rise && i_href))) begin
        r_line_err <= 1'b1;
      end
    end
  end

  assign o_we         = r_we;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_line_err   = r_line_err;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// tb/tb_ov7670_capture_ctrl.sv - directed bench for ov7670_capture_ctrl
module tb_ov7670_capture_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic       pclk = 1'b0;
  logic       reset;
  logic       cen;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  logic        d1_we, d1_busy, d1_fd, d1_lerr;
  logic [4:0]  d1_waddr;
  logic [15:0] d1_wdata;
  logic [7:0]  d1_fcnt;
  logic        d2_we, d2_busy, d2_fd, d2_lerr;
  logic [4:0]  d2_waddr;
  logic [15:0] d2_wdata;
  logic [7:0]  d2_fcnt;
  logic        p3_we, p3_busy, p3_fd, p3_lerr;
  logic [4:0]  p3_waddr;
  logic [11:0] p3_wdata;
  logic [7:0]  p3_fcnt;

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .PIX_W(16), .ADDR_W(5)) u_d1 (
    .pclk(pclk), .reset(reset), .i_capture_en(cen), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_we(d1_we), .o_waddr(d1_waddr), .o_wdata(d1_wdata), .o_busy(d1_busy),
    .o_frame_done(d1_fd), .o_frame_cnt(d1_fcnt), .o_line_err(d1_lerr));

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .PIX_W(16), .ADDR_W(5)) u_d2 (
    .pclk(pclk), .reset(reset), .i_capture_en(cen), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_we(d2_we), .o_waddr(d2_waddr), .o_wdata(d2_wdata), .o_busy(d2_busy),
    .o_frame_done(d2_fd), .o_frame_cnt(d2_fcnt), .o_line_err(d2_lerr));

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .PIX_W(12), .ADDR_W(5)) u_p3 (
    .pclk(pclk), .reset(reset), .i_capture_en(cen), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_we(p3_we), .o_waddr(p3_waddr), .o_wdata(p3_wdata), .o_busy(p3_busy),
    .o_frame_done(p3_fd), .o_frame_cnt(p3_fcnt), .o_line_err(p3_lerr));

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int cyc = 0;
  int fd1 = 0;
  int q1_a[$], q1_d[$], q1_c[$], q2_a[$], q2_d[$], q3_d[$];

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (d1_we) begin
      q1_a.push_back(int'(d1_waddr));
      q1_d.push_back(int'(d1_wdata));
      q1_c.push_back(cyc);
    end
    if (d2_we) begin
      q2_a.push_back(int'(d2_waddr));
      q2_d.push_back(int'(d2_wdata));
    end
    if (p3_we) q3_d.push_back(int'(p3_wdata));
    if (d1_fd) fd1 <= fd1 + 1;
  end

  // ---------------- stimulus and model ----------------
  logic [15:0] pix_mem [0:5][0:15];
  int line_bytes [0:5];
  int n_lines;
  int b1, b2, b3, fd_b, t_b1;
  int e_a[$], e_d[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic init_pix();
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 16; x++)
        pix_mem[y][x] = {8'h12 + 8'(y * 16 + x), 8'h34 + 8'(y * 16 + x)};
    for (int y = 0; y < 6; y++) line_bytes[y] = 2 * H;
    n_lines = V;
  endtask

  task automatic mark();
    b1   = q1_a.size();
    b2   = q2_a.size();
    b3   = q3_d.size();
    fd_b = fd1;
  endtask

  task automatic send_frame(input int rst_line, input int drop_line);
    mark();
    vsync = 1'b1; href = 1'b0;
    tick(3);
    vsync = 1'b0;
    tick(4);
    for (int y = 0; y < n_lines; y++) begin
      if (y == rst_line) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mark();
      end
      if (y == drop_line) cen = 1'b0;
      for (int b = 0; b < line_bytes[y]; b++) begin
        href = 1'b1;
        data = (b % 2 == 1) ? pix_mem[y][b / 2][7:0] : pix_mem[y][b / 2][15:8];
        tick(1);
        if (y == 0 && b == 1) t_b1 = cyc;
      end
      href = 1'b0;
      data = 8'h00;
      tick(4);
    end
    vsync = 1'b1;
    tick(3);
  endtask

  // Expected writes of a DECIM=d instance for the frame just sent.
  task automatic build_expected(input int d);
    int np;
    e_a.delete();
    e_d.delete();
    for (int y = 0; y < n_lines; y++) begin
      if (y < V && y % d == 0) begin
        np = line_bytes[y] / 2;
        if (np > H) np = H;
        for (int x = 0; x < np; x++)
          if (x % d == 0) begin
            e_a.push_back((y / d) * (H / d) + x / d);
            e_d.push_back(int'(pix_mem[y][x]));
          end
      end
    end
  endtask

  task automatic cmp_writes(input string tag, input int sel);
    int wa[$], wd[$];
    if (sel == 1) begin
      for (int i = b1; i < q1_a.size(); i++) begin wa.push_back(q1_a[i]); wd.push_back(q1_d[i]); end
    end else begin
      for (int i = b2; i < q2_a.size(); i++) begin wa.push_back(q2_a[i]); wd.push_back(q2_d[i]); end
    end
    chk({tag, " writes"}, wa.size(), e_a.size());
    for (int i = 0; i < wa.size() && i < e_a.size(); i++) begin
      chk($sformatf("%s waddr[%0d]", tag, i), wa[i], e_a[i]);
      chk($sformatf("%s wdata[%0d]", tag, i), wd[i], e_d[i]);
    end
  endtask

  initial begin
    reset = 1'b1; cen = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    init_pix();
    tick(3);
    chk("rst we", d1_we, 0);
    chk("rst busy", d1_busy, 0);
    chk("rst frame_done", d1_fd, 0);
    chk("rst frame_cnt", d1_fcnt, 0);
    chk("rst line_err", d1_lerr, 0);
    chk("rst waddr", d1_waddr, 0);
    chk("rst wdata", d1_wdata, 0);
    reset = 1'b0;
    cen = 1'b1;
    tick(2);
    chk("sync busy", d1_busy, 1);

    // F1: clean frame, all three configurations
    send_frame(-1, -1);
    build_expected(1); cmp_writes("f1 d1", 1);
    build_expected(2); cmp_writes("f1 d2", 2);
    chk("f1 we latency", q1_c[b1], t_b1);
    chk("f1 frame_done", fd1 - fd_b, 1);
    chk("f1 frame_cnt", d1_fcnt, 1);
    chk("f1 line_err", d1_lerr, 0);
    chk("f1 p12 writes", q3_d.size() - b3, 32);
    chk("f1 p12 wdata0", q3_d[b3], 32'h14A);

    // F2: short line 1, long line 2, extra line beyond V_ACTIVE
    pix_mem[0][0] = 16'hF81F;
    pix_mem[0][1] = 16'h07E0;
    line_bytes[1] = 15;
    line_bytes[2] = 20;
    n_lines = 5;
    send_frame(-1, -1);
    build_expected(1); cmp_writes("f2 d1", 1);
    build_expected(2); cmp_writes("f2 d2", 2);
    chk("f2 line_err", d1_lerr, 1);
    chk("f2 p12 F81F", q3_d[b3], 32'hF0F);
    chk("f2 p12 07E0", q3_d[b3 + 1], 32'h0F0);
    chk("f2 frame_cnt", d1_fcnt, 2);

    // F3: clean frame clears line_err on capture entry
    init_pix();
    send_frame(-1, -1);
    build_expected(1); cmp_writes("f3 d1", 1);
    chk("f3 line_err", d1_lerr, 0);
    chk("f3 frame_cnt", d1_fcnt, 3);

    // F4: reset at line 2 -> nothing written for the rest of the frame
    send_frame(2, -1);
    chk("f4 writes after reset", q1_a.size() - b1, 0);
    chk("f4 d2 writes after reset", q2_a.size() - b2, 0);
    chk("f4 frame_done", fd1 - fd_b, 0);
    chk("f4 frame_cnt", d1_fcnt, 0);
    chk("f4 busy", d1_busy, 1);

    // F5: next full vsync pulse restarts at waddr 0
    send_frame(-1, -1);
    build_expected(1); cmp_writes("f5 d1", 1);
    chk("f5 frame_cnt", d1_fcnt, 1);

    // F6: capture_en dropped at line 1 -> frame completes, then idle
    send_frame(-1, 1);
    build_expected(1); cmp_writes("f6 d1", 1);
    chk("f6 frame_done", fd1 - fd_b, 1);
    chk("f6 frame_cnt", d1_fcnt, 2);
    chk("f6 busy", d1_busy, 0);

    // F7: idle -> following frame ignored
    send_frame(-1, -1);
    chk("f7 writes", q1_a.size() - b1, 0);
    chk("f7 frame_done", fd1 - fd_b, 0);
    chk("f7 frame_cnt", d1_fcnt, 2);
    chk("f7 busy", d1_busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_ctrl.md
OV7670_CAPTURE_CTRL -- requirements
Module: ov7670_capture_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per camera line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per camera frame.
REQ-003 Parameter DECIM, default 2, decimation factor in x and y; legal values 1, 2, 4.
REQ-004 Parameter PIX_W, default 16, stored pixel width; 16 = RGB565, 12 = RGB444.
REQ-005 Parameter ADDR_W, default 17, buffer address width; must satisfy 2^ADDR_W >= (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM).
REQ-006 pclk  in  1  camera pixel clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high, sampled on pclk.
REQ-008 capture_en  in  1  request continuous frame capture.
REQ-009 vsync  in  1  camera frame sync, high = vertical blanking.
REQ-010 href  in  1  camera line valid, high = byte on data is valid.
REQ-011 data  in  8  camera byte stream, two bytes per pixel.
REQ-012 we  out  1  frame-buffer write strobe, one pclk wide.
REQ-013 waddr  out  ADDR_W  frame-buffer write address.
REQ-014 wdata  out  PIX_W  frame-buffer write pixel.
REQ-015 busy  out  1  high while in SYNC or CAPTURE state.
REQ-016 frame_done  out  1  one-pclk pulse at end of each captured frame.
REQ-017 frame_cnt  out  8  count of completed frames, wraps 255 -> 0.
REQ-018 line_err  out  1  sticky flag: malformed line seen in current/last frame.

Function
REQ-019 FSM states SHALL be IDLE, SYNC, CAPTURE.
REQ-020 IDLE -> SYNC when capture_en = 1; SYNC -> CAPTURE on vsync falling edge (registered vsync 1 -> 0) seen after vsync was high in SYNC.
REQ-021 CAPTURE -> SYNC on vsync rising edge if capture_en = 1, else CAPTURE -> IDLE; frame_done pulses and frame_cnt increments on that edge.
REQ-022 capture_en deasserted mid-frame SHALL NOT abort; current frame completes, then IDLE.
REQ-023 In CAPTURE, bytes with href = 1 pair up: first byte -> pixel[15:8], second -> pixel[7:0]; byte phase resets to first on every href falling edge.
REQ-024 Pixel column x and line y counters start at 0 each line/frame; y increments on href falling edge.
REQ-025 A pixel is written only if x < H_ACTIVE, y < V_ACTIVE, x mod DECIM = 0 and y mod DECIM = 0.
REQ-026 waddr = (y/DECIM)*(H_ACTIVE/DECIM) + x/DECIM, computed without multiplier (running line-base register advanced by H_ACTIVE/DECIM per kept line).
REQ-027 PIX_W = 12: wdata = {p[15:12], p[10:7], p[4:1]}; PIX_W = 16: wdata = p.
REQ-028 we, waddr, wdata SHALL be registered and asserted exactly 1 pclk after the second byte of a kept pixel is sampled.
REQ-029 Pixels beyond H_ACTIVE and lines beyond V_ACTIVE SHALL be discarded silently (no we, no wrap).
REQ-030 line_err sets when href falls with byte count != 2*H_ACTIVE (incl. odd count); cleared on entry to CAPTURE.
REQ-031 vsync rising while href = 1 SHALL end the frame normally and set line_err.
REQ-032 we SHALL never assert outside CAPTURE.

Reset
REQ-033 On reset: state = IDLE; we, busy, frame_done, line_err = 0; waddr, wdata, frame_cnt = 0; x, y, byte phase cleared.
REQ-034 Reset mid-frame SHALL force IDLE; no write occurs until a full vsync high -> low is seen in SYNC.

Structure
REQ-035 Shared package cam_pkg SHALL hold the FSM state enum and RGB565->RGB444 packing function.
REQ-036 One sub-module, cam_byte_pairer (byte phase, pixel assembly, href edge detect), is natural; counters, addressing and FSM stay in top.

Verification
REQ-037 H_ACTIVE=8, V_ACTIVE=4, DECIM=1, PIX_W=16: one frame bytes 0x12,0x34,... -> 32 writes, waddr 0..31, first wdata 0x1234, frame_done once, frame_cnt=1.
REQ-038 Same frame, DECIM=2 -> 8 writes, waddr 0..7 from pixels (0,0),(2,0),(4,0),(6,0),(0,2)...; no writes on odd lines.
REQ-039 PIX_W=12, pixel 0xF81F -> wdata 0xF0F; pixel 0x07E0 -> 0x0F0.
REQ-040 Line 1 with 15 bytes -> line_err=1 after href falls; writes of other lines unaffected; line_err=0 after next CAPTURE entry.
REQ-041 Reset asserted at line 2 of frame -> we=0 for remainder of frame; first write at waddr 0 only after next full vsync pulse.
REQ-042 capture_en dropped at line 1 -> frame completes (frame_done pulse), busy=0, no writes in following frame.
